// File: rtl/decrypt_iter.sv
// PRESENT-80 iterative decryption core.
// The forward key schedule is run first to reach the last round key.
// The rounds are then undone one per clock while the key schedule steps backwards.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_IDLE    | waiting for start; ready=1; M/valid hold the last result
//  S_EXPAND  | forward key schedule, one update per clock, counter 1..ROUNDS
//  S_DECRYPT | one inverse round per clock, counter ROUNDS down to 1
module decrypt_iter #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [79:0] K,
    input  logic [63:0] C,
    output logic        ready,
    output logic [63:0] M,
    output logic        valid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXPAND  = 2'd1;
    localparam logic [1:0] S_DECRYPT = 2'd2;

    localparam logic [4:0] LAST = 5'(ROUNDS);

    logic [1:0]  fsm;
    logic [4:0]  cnt;
    logic [79:0] key_q;
    logic [63:0] state_q;

    logic [79:0] key_fwd_next;
    logic [79:0] key_prev;
    logic [63:0] round_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Forward key update: rotate left 61, S-box top nibble, fold in round number.
    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r = {k[18:0], k[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ c;
        return r;
    endfunction

    // Exact inverse of key_fwd for the same round number.
    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r = k;
        r[19:15] = r[19:15] ^ c;
        r[79:76] = inv_sbox(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    // Output bit j takes input bit 16*j mod 63; bit 63 stays in place.
    function automatic logic [63:0] inv_player(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) begin
            y[j] = x[(16 * j) % 63];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_slayer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Round datapath shared by both phases; the counter selects the round constant.
    always_comb begin
        key_fwd_next = key_fwd(key_q, cnt);
        key_prev     = key_inv(key_q, cnt);
        round_out    = inv_slayer(inv_player(state_q)) ^ key_prev[79:16];
    end

    assign ready = (fsm == S_IDLE);

    // Sequencer: latch on start, expand the key, then peel rounds until counter reaches 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= S_IDLE;
            cnt     <= '0;
            key_q   <= '0;
            state_q <= '0;
            M       <= '0;
            valid   <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        state_q <= C;
                        key_q   <= K;
                        cnt     <= 5'd1;
                        valid   <= 1'b0;
                        fsm     <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    key_q <= key_fwd_next;
                    if (cnt == LAST) begin
                        // Whitening uses the freshly computed final round key.
                        state_q <= state_q ^ key_fwd_next[79:16];
                        fsm     <= S_DECRYPT;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_DECRYPT: begin
                    state_q <= round_out;
                    key_q   <= key_prev;
                    cnt     <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        M     <= round_out;
                        valid <= 1'b1;
                        fsm   <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decrypt_iter.sv
// Self-checking bench for decrypt_iter: known-answer table, handshake corner
// cases, async reset mid-operation and random loopback against a PRESENT model.
module tb_decrypt_iter;

    localparam int ROUNDS  = 31;
    localparam int LATENCY = 2 * ROUNDS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] K;
    logic [63:0] C;
    logic        ready;
    logic [63:0] M;
    logic        valid;

    int checks = 0;
    int errors = 0;

    decrypt_iter #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .K     (K),
        .C     (C),
        .ready (ready),
        .M     (M),
        .valid (valid)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    // Reference PRESENT-80 encryption straight from the cipher definition.
    function automatic logic [63:0] ref_enc(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] s;
        logic [63:0] t;
        logic [79:0] k;
        int          dst;
        s = pt;
        k = key;
        for (int r = 1; r <= ROUNDS; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
            for (int j = 0; j < 64; j++) begin
                dst = (j == 63) ? 63 : (16 * j) % 63;
                s[dst] = t[j];
            end
            k = (k << 61) | (k >> 19);
            k[79:76] = SB[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one start and wait (bounded) for valid; returns result and edges to valid.
    task automatic run_op(input logic [79:0] k, input logic [63:0] c,
                          output logic [63:0] m, output int lat);
        @(negedge clk);
        K = k;
        C = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        chk_int("valid_drops_on_accept", int'(valid), 0);
        chk_int("busy_not_ready", int'(ready), 0);
        while (!valid && lat < 4 * LATENCY) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no valid after %0d cycles expected %0d", lat, LATENCY);
        end
        m = M;
    endtask

    typedef struct {
        logic [79:0] k;
        logic [63:0] c;
        logic [63:0] m;
    } vec_t;

    vec_t        vecs[4];
    logic [63:0] res;
    logic [79:0] rk;
    logic [63:0] rm;
    logic [63:0] rc;
    int          lat;

    initial begin
        vecs[0] = '{k: 80'h0,                    c: 64'h5579C1387B228445, m: 64'h0};
        vecs[1] = '{k: 80'hFFFFFFFFFFFFFFFFFFFF, c: 64'hE72C46C0F5945049, m: 64'h0};
        vecs[2] = '{k: 80'h0,                    c: 64'hA112FFC72F68417B, m: 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{k: 80'hFFFFFFFFFFFFFFFFFFFF, c: 64'h3333DCD3213210D2, m: 64'hFFFFFFFFFFFFFFFF};

        rst = 1'b1;
        start = 1'b0;
        K = '0;
        C = '0;
        #1;
        chk_int("reset_ready", int'(ready), 1);
        chk_int("reset_valid", int'(valid), 0);
        chk64("reset_M", M, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle start=0 must not disturb anything.
        repeat (3) @(posedge clk);
        #1;
        chk_int("idle_ready", int'(ready), 1);
        chk_int("idle_valid", int'(valid), 0);

        // Known-answer table, issued back-to-back in the valid cycle.
        for (int i = 0; i < 4; i++) begin
            run_op(vecs[i].k, vecs[i].c, res, lat);
            chk64($sformatf("kat%0d_M", i), res, vecs[i].m);
            chk_int($sformatf("kat%0d_latency", i), lat, LATENCY);
            chk_int($sformatf("kat%0d_ready_done", i), int'(ready), 1);
        end

        // Inputs changing and start pulsing while busy must be ignored.
        @(negedge clk);
        K = vecs[1].k;
        C = vecs[1].c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 4 * LATENCY) begin
            @(negedge clk);
            if (lat == 10 || lat == 45) begin
                K = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
                C = {$urandom, $urandom};
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            #1;
        end
        start = 1'b0;
        chk64("busy_ignore_M", M, vecs[1].m);
        chk_int("busy_ignore_latency", lat, LATENCY);
        repeat (5) @(posedge clk);
        #1;
        chk_int("start_not_queued_valid", int'(valid), 1);
        chk_int("start_not_queued_ready", int'(ready), 1);
        chk64("result_holds", M, vecs[1].m);

        // Async reset in the middle of DECRYPT.
        run_op(vecs[2].k, vecs[2].c, res, lat);
        chk64("pre_reset_M", res, vecs[2].m);
        @(negedge clk);
        K = vecs[0].k;
        C = vecs[0].c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_int("midrun_reset_ready", int'(ready), 1);
        chk_int("midrun_reset_valid", int'(valid), 0);
        chk64("midrun_reset_M", M, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(vecs[3].k, vecs[3].c, res, lat);
        chk64("post_reset_M", res, vecs[3].m);
        chk_int("post_reset_latency", lat, LATENCY);

        // Random loopback through the reference encryptor.
        for (int n = 0; n < 1000; n++) begin
            rk = {$urandom, $urandom, 16'($urandom_range(0, 65535))};
            rm = {$urandom, $urandom};
            rc = ref_enc(rk, rm);
            run_op(rk, rc, res, lat);
            chk64($sformatf("loop%0d_M", n), res, rm);
            chk_int($sformatf("loop%0d_latency", n), lat, LATENCY);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
